// File: rtl/fir_decim_buf.sv
// Decimating output buffer for the FIR filter path.
// Keeps every DECIM-th valid sample (first one after reset included) and
// queues it in a small first-word-fall-through FIFO for the downstream consumer.
// A kept sample that finds the buffer full is dropped and latches overflow.
module fir_decim_buf #(
  parameter int DW    = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DW-1:0]              x_in,
  output logic [DW-1:0]              out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          keep;
  logic          full;
  logic          push;
  logic          pop;

  assign keep      = in_valid && (phase == '0);
  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full buffer can still accept.
  assign push      = keep && (!full || pop);
  // Storage is not reset, so the head is masked to zero while the buffer is empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Decimation phase: advances on every valid sample, stored or dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase == PW'(DECIM - 1)) phase <= '0;
      else                         phase <= phase + PW'(1);
    end
  end

  // Sample storage; written only when a kept sample is accepted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= x_in;
  end

  // Pointers wrap naturally since DEPTH is a power of two; occupancy tracks push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a kept sample lost because the buffer stayed full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     overflow <= 1'b0;
    else if (keep && full && !pop) overflow <= 1'b1;
  end

endmodule
